// File: rtl/dm_arbiter.sv
// Round-robin arbiter between two data-memory masters: each grant becomes one
// DM strobe cycle followed by a one-cycle acknowledge back to the winner.
module dm_arbiter #(
   parameter int DMSIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_signed,
   input  logic [2:0]  m0_bytes,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m0_pc,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_signed,
   input  logic [2:0]  m1_bytes,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [31:0] m1_pc,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        dm_we,
   output logic        dm_re,
   output logic        dm_signed,
   output logic [2:0]  dm_bytes,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_din,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic        gnt;
   logic        last_gnt;
   logic        err_q;
   logic        we_q;
   logic        we_stb;
   logic        re_stb;
   logic        ack0_q;
   logic        ack1_q;
   logic        sel;
   logic        c_we;
   logic        c_signed;
   logic        c_err;
   logic [2:0]  c_bytes;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] c_pc;
   logic [32:0] c_end;
   logic [31:0] rd_capture;

   // A lone request wins outright; a conflict goes to whoever was not served last.
   always_comb begin
      sel      = (m0_req && m1_req) ? ~last_gnt : m1_req;
      c_we     = sel ? m1_we     : m0_we;
      c_signed = sel ? m1_signed : m0_signed;
      c_bytes  = sel ? m1_bytes  : m0_bytes;
      c_addr   = sel ? m1_addr   : m0_addr;
      c_wdata  = sel ? m1_wdata  : m0_wdata;
      c_pc     = sel ? m1_pc     : m0_pc;
      c_end    = {1'b0, c_addr} + {30'd0, c_bytes};
      c_err    = !(c_bytes == 3'd1 || c_bytes == 3'd2 || c_bytes == 3'd4)
               || (c_bytes == 3'd2 && c_addr[0])
               || (c_bytes == 3'd4 && c_addr[1:0] != 2'd0)
               || (c_end > 33'(DMSIZE));
   end

   assign rd_capture = (err_q || we_q) ? 32'd0 : dm_dout;

   // Strobes and acks are masked during reset so an interrupted access never commits or completes.
   assign dm_we  = we_stb & ~reset;
   assign dm_re  = re_stb & ~reset;
   assign m0_ack = ack0_q & ~reset;
   assign m1_ack = ack1_q & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last_gnt  <= 1'b1;
         err_q     <= 1'b0;
         we_q      <= 1'b0;
         we_stb    <= 1'b0;
         re_stb    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
         dm_signed <= 1'b0;
         dm_bytes  <= 3'd0;
         dm_addr   <= 32'd0;
         dm_din    <= 32'd0;
         dm_pc     <= 32'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  gnt       <= sel;
                  last_gnt  <= sel;
                  err_q     <= c_err;
                  we_q      <= c_we;
                  we_stb    <= !c_err && c_we;
                  re_stb    <= !c_err && !c_we;
                  dm_signed <= c_signed;
                  dm_bytes  <= c_bytes;
                  dm_addr   <= c_addr;
                  dm_din    <= c_wdata;
                  dm_pc     <= c_pc;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               we_stb   <= 1'b0;
               re_stb   <= 1'b0;
               ack0_q   <= ~gnt;
               ack1_q   <= gnt;
               m0_err   <= ~gnt & err_q;
               m1_err   <= gnt & err_q;
               m0_rdata <= gnt ? 32'd0 : rd_capture;
               m1_rdata <= gnt ? rd_capture : 32'd0;
               state    <= DONE;
            end
            DONE: begin
               ack0_q   <= 1'b0;
               ack1_q   <= 1'b0;
               m0_err   <= 1'b0;
               m1_err   <= 1'b0;
               m0_rdata <= 32'd0;
               m1_rdata <= 32'd0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
